// File: rtl/conv_fprop2_mul_pipe_if.sv
// rtl/conv_fprop2_mul_pipe_if.sv - operand/result handshake bundle for conv_fprop2_mul_pipe
interface conv_fprop2_mul_pipe_if #(
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  acc_en;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [dout_WIDTH-1:0] dout;
  logic                  dout_ovf;

  modport master (
    output in_valid, din0, din1, acc_en, in_last, out_ready,
    input  in_ready, out_valid, dout, dout_ovf
  );

  modport slave (
    input  in_valid, din0, din1, acc_en, in_last, out_ready,
    output in_ready, out_valid, dout, dout_ovf
  );
endinterface

// File: rtl/conv_fprop2_mul_pipe.sv
// rtl/conv_fprop2_mul_pipe.sv - pipelined multiplier / MAC with global-stall flow control
module conv_fprop2_mul_pipe #(
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 10,
  parameter int dout_WIDTH = 10,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_STAGE  = 3,
  parameter int SIGNED     = 1,
  parameter int SAT        = 0
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  conv_fprop2_mul_pipe_if.slave  io
);
  localparam int PW  = din0_WIDTH + din1_WIDTH;
  // Register stages ahead of the output/accumulator stage
  localparam int D   = NUM_STAGE - 1;
  // Formatting width: one spare bit above both the source and the result so
  // the range test always has at least one bit to inspect
  localparam int XW  = ((ACC_WIDTH > dout_WIDTH) ? ACC_WIDTH : dout_WIDTH) + 1;
  localparam bit SGN = (SIGNED != 0);

  logic                  en;
  logic                  out_valid_q;
  logic [dout_WIDTH-1:0] dout_q;
  logic                  ovf_q;

  // Whole pipe moves only when the output register is empty or being drained
  assign en           = !out_valid_q || io.out_ready;
  assign io.in_ready  = en;
  assign io.out_valid = out_valid_q;
  assign io.dout      = dout_q;
  assign io.dout_ovf  = ovf_q;

  logic [PW-1:0] a_ext, b_ext, prod;

  // Full-width product; extending both operands to PW makes the low PW bits exact
  always_comb begin
    a_ext = {{din1_WIDTH{SGN & io.din0[din0_WIDTH-1]}}, io.din0};
    b_ext = {{din0_WIDTH{SGN & io.din1[din1_WIDTH-1]}}, io.din1};
    prod  = a_ext * b_ext;
  end

  logic          fin_valid, fin_acc, fin_last;
  logic [PW-1:0] fin_p;

  generate
    if (D == 0) begin : g_direct
      assign fin_valid = io.in_valid;
      assign fin_acc   = io.acc_en;
      assign fin_last  = io.in_last;
      assign fin_p     = prod;
    end else begin : g_pipe
      logic [D-1:0]  v_q, a_q, l_q;
      logic [PW-1:0] p_q [D];

      // Delay line carrying the product with its valid/accumulate/last tags
      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          v_q <= '0;
          a_q <= '0;
          l_q <= '0;
          for (int i = 0; i < D; i++) p_q[i] <= '0;
        end else if (en) begin
          v_q[0] <= io.in_valid;
          a_q[0] <= io.acc_en;
          l_q[0] <= io.in_last;
          p_q[0] <= prod;
          for (int i = 1; i < D; i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
            l_q[i] <= l_q[i-1];
            p_q[i] <= p_q[i-1];
          end
        end
      end

      assign fin_valid = v_q[D-1];
      assign fin_acc   = a_q[D-1];
      assign fin_last  = l_q[D-1];
      assign fin_p     = p_q[D-1];
    end
  endgenerate

  logic [ACC_WIDTH-1:0]  acc_q, p_acc, val;
  logic                  wrap_q;
  logic [ACC_WIDTH:0]    sum_w;
  logic                  sum_ovf;
  logic [XW-1:0]         vx;
  logic                  trunc_ovf;
  logic [dout_WIDTH-1:0] fmt;

  // Accumulator add with overflow detect, then truncate or clamp to dout_WIDTH
  always_comb begin
    if (SGN) p_acc = ACC_WIDTH'($signed(fin_p));
    else     p_acc = ACC_WIDTH'(fin_p);
    sum_w = {1'b0, acc_q} + {1'b0, p_acc};
    if (SGN)
      sum_ovf = (acc_q[ACC_WIDTH-1] == p_acc[ACC_WIDTH-1]) &&
                (sum_w[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    else
      sum_ovf = sum_w[ACC_WIDTH];
    val = fin_acc ? sum_w[ACC_WIDTH-1:0] : p_acc;
    if (SGN) vx = XW'($signed(val));
    else     vx = XW'(val);
    // Out of range exactly when the dropped bits are not an extension of the kept ones
    trunc_ovf = vx[XW-1:dout_WIDTH] != {(XW-dout_WIDTH){SGN & vx[dout_WIDTH-1]}};
    fmt = vx[dout_WIDTH-1:0];
    if ((SAT != 0) && trunc_ovf) begin
      if (!SGN) begin
        fmt = '1;
      end else if (vx[XW-1]) begin
        fmt = '0;
        fmt[dout_WIDTH-1] = 1'b1;
      end else begin
        fmt = '1;
        fmt[dout_WIDTH-1] = 1'b0;
      end
    end
  end

  // Output stage: emit plain results and closing sums, fold non-last beats into acc
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      wrap_q      <= 1'b0;
    end else if (en) begin
      out_valid_q <= fin_valid && (!fin_acc || fin_last);
      if (fin_valid && !fin_acc) begin
        dout_q <= fmt;
        ovf_q  <= trunc_ovf;
      end else if (fin_valid && fin_last) begin
        dout_q <= fmt;
        ovf_q  <= trunc_ovf | wrap_q | sum_ovf;
        acc_q  <= '0;
        wrap_q <= 1'b0;
      end else if (fin_valid) begin
        acc_q  <= sum_w[ACC_WIDTH-1:0];
        wrap_q <= wrap_q | sum_ovf;
      end
    end
  end
endmodule

// File: tb/tb_conv_fprop2_mul_pipe.sv
// tb/tb_conv_fprop2_mul_pipe.sv - scoreboard bench over truncating, clamping and wide-output instances
module tb_conv_fprop2_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         cyc = 0;
  int         checks;
  int         errors;
  logic       in_valid, acc_en, in_last, out_ready;
  logic [9:0] din0, din1;

  always @(posedge clk) cyc <= cyc + 1;

  conv_fprop2_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(10), .dout_WIDTH(10)) if_a ();
  conv_fprop2_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(10), .dout_WIDTH(10)) if_b ();
  conv_fprop2_mul_pipe_if #(.din0_WIDTH(10), .din1_WIDTH(10), .dout_WIDTH(20)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_b.in_valid = in_valid;  assign if_c.in_valid = in_valid;
  assign if_a.din0 = din0;          assign if_b.din0 = din0;          assign if_c.din0 = din0;
  assign if_a.din1 = din1;          assign if_b.din1 = din1;          assign if_c.din1 = din1;
  assign if_a.acc_en = acc_en;      assign if_b.acc_en = acc_en;      assign if_c.acc_en = acc_en;
  assign if_a.in_last = in_last;    assign if_b.in_last = in_last;    assign if_c.in_last = in_last;
  assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready; assign if_c.out_ready = out_ready;

  conv_fprop2_mul_pipe #(.SAT(0)) u_a (.ap_clk(clk), .ap_rst_n(rst_n), .io(if_a.slave));
  conv_fprop2_mul_pipe #(.SAT(1)) u_b (.ap_clk(clk), .ap_rst_n(rst_n), .io(if_b.slave));
  conv_fprop2_mul_pipe #(.dout_WIDTH(20), .ACC_WIDTH(20)) u_c (.ap_clk(clk), .ap_rst_n(rst_n), .io(if_c.slave));

  typedef struct {
    logic [9:0]  da;
    logic        oa;
    logic [9:0]  db;
    logic        ob;
    logic [19:0] dc;
    logic        oc;
    int          due;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic expect_out(input logic [9:0] da, input logic oa, input logic [9:0] db, input logic ob,
                            input logic [19:0] dc, input logic oc, input int due);
    exp_t e;
    e.da = da; e.oa = oa; e.db = db; e.ob = ob; e.dc = dc; e.oc = oc; e.due = due;
    sb.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accepting edge
  task automatic send(input int a, input int b, input logic ae, input logic la, output int t);
    int n;
    in_valid = 1'b1;
    din0     = 10'(a);
    din1     = 10'(b);
    acc_en   = ae;
    in_last  = la;
    n = 0;
    @(negedge clk);
    while (!if_a.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=stalled exp=accepted");
    end
    t = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_en   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid_a"}, 32'(if_a.out_valid), 32'd0);
    chk({tag, "_dout_a"},  32'(if_a.dout),      32'd0);
    chk({tag, "_ovf_a"},   32'(if_a.dout_ovf),  32'd0);
    chk({tag, "_ready_a"}, 32'(if_a.in_ready),  32'd1);
    chk({tag, "_valid_c"}, 32'(if_c.out_valid), 32'd0);
    chk({tag, "_dout_c"},  32'(if_c.dout),      32'd0);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb.size());
    end
  endtask

  logic       prev_stall;
  logic [9:0] prev_da;
  logic       prev_oa;

  // Monitor: handshake rule, stall stability, and in-order compare against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 32'(if_a.in_ready), 32'(!(if_a.out_valid && !out_ready)));
      if (prev_stall) begin
        chk("stall_valid", 32'(if_a.out_valid), 32'd1);
        chk("stall_dout",  32'(if_a.dout),      32'(prev_da));
        chk("stall_ovf",   32'(if_a.dout_ovf),  32'(prev_oa));
      end
      if (if_a.out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got=%h exp=none", if_a.dout);
        end else begin
          e = sb.pop_front();
          chk("valid_b", 32'(if_b.out_valid), 32'd1);
          chk("valid_c", 32'(if_c.out_valid), 32'd1);
          chk("dout_a",  32'(if_a.dout),      32'(e.da));
          chk("ovf_a",   32'(if_a.dout_ovf),  32'(e.oa));
          chk("dout_b",  32'(if_b.dout),      32'(e.db));
          chk("ovf_b",   32'(if_b.dout_ovf),  32'(e.ob));
          chk("dout_c",  32'(if_c.dout),      32'(e.dc));
          chk("ovf_c",   32'(if_c.dout_ovf),  32'(e.oc));
          if (e.due >= 0) chk("latency", 32'(cyc), 32'(e.due));
        end
      end
      prev_stall = if_a.out_valid && !out_ready;
      prev_da    = if_a.dout;
      prev_oa    = if_a.dout_ovf;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    din0      = '0;
    din1      = '0;
    acc_en    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst");
    @(posedge clk);
    #1;

    // Plain products: sign, truncation, clamping, extreme operands
    send(-3, 7, 1'b0, 1'b0, t);
    expect_out(10'h3EB, 1'b0, 10'h3EB, 1'b0, 20'hFFFEB, 1'b0, t + 3);
    send(300, 3, 1'b0, 1'b0, t);
    expect_out(10'h384, 1'b1, 10'h1FF, 1'b1, 20'h00384, 1'b0, -1);
    send(-300, 3, 1'b0, 1'b0, t);
    expect_out(10'h07C, 1'b1, 10'h200, 1'b1, 20'hFFC7C, 1'b0, -1);
    send(-512, -512, 1'b0, 1'b0, t);
    expect_out(10'h000, 1'b1, 10'h1FF, 1'b1, 20'h40000, 1'b0, -1);
    wait_drain();
    @(posedge clk);
    #1;

    // Accumulate 6 + 20 - 6, then a one-beat sequence proving acc cleared
    send(2, 3, 1'b1, 1'b0, t);
    send(4, 5, 1'b1, 1'b0, t);
    send(-1, 6, 1'b1, 1'b1, t);
    expect_out(10'h014, 1'b0, 10'h014, 1'b0, 20'h00014, 1'b0, -1);
    send(1, 1, 1'b1, 1'b1, t);
    expect_out(10'h001, 1'b0, 10'h001, 1'b0, 20'h00001, 1'b0, -1);
    wait_drain();
    @(posedge clk);
    #1;

    // Back-to-back stream with the output stalled mid-way
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          send(k, 1, 1'b0, 1'b0, t);
          expect_out(10'(k), 1'b0, 10'(k), 1'b0, 20'(k), 1'b0, -1);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    #1;

    // 4 x 261121: wraps a 20-bit accumulator, fits a 24-bit one
    for (int i = 0; i < 4; i++) send(511, 511, 1'b1, (i == 3), t);
    expect_out(10'h004, 1'b1, 10'h1FF, 1'b1, 20'hFF004, 1'b1, -1);
    wait_drain();
    @(posedge clk);
    #1;

    // Partial sum and an in-flight plain beat are discarded by reset
    send(5, 5, 1'b1, 1'b0, t);
    send(5, 5, 1'b1, 1'b0, t);
    repeat (5) @(posedge clk);
    #1;
    send(7, 7, 1'b0, 1'b0, t);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    @(posedge clk);
    #1;
    send(1, 2, 1'b1, 1'b1, t);
    expect_out(10'h002, 1'b0, 10'h002, 1'b0, 20'h00002, 1'b0, -1);
    wait_drain();
    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/conv_fprop2_mul_pipe.md
# conv_fprop2_mul_pipe

Parametrised, pipelined signed/unsigned multiplier with optional multiply-accumulate mode, valid/ready flow control and configurable output formatting. Each accepted operand pair produces one result, or a running sum is emitted once per `in_last`. It replaces the combinational HLS multiplier cores in the conv_fprop2 datapath where timing closure needs registered stages and downstream backpressure.

## Interface
Parameters:
- `din0_WIDTH`, default 10: operand A width.
- `din1_WIDTH`, default 10: operand B width.
- `dout_WIDTH`, default 10: result width.
- `ACC_WIDTH`, default 24: accumulator width. Must be >= `din0_WIDTH + din1_WIDTH`.
- `NUM_STAGE`, default 3: accept-to-output latency in cycles. Must be >= 1.
- `SIGNED`, default 1: 1 = two's-complement operands and result, 0 = unsigned.
- `SAT`, default 0: 0 = truncate to the low `dout_WIDTH` bits, 1 = clamp to the `dout_WIDTH` range.

Ports:
- `ap_clk` in 1: the single clock. All state updates on its rising edge.
- `ap_rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat.
- `din0` in `din0_WIDTH`: operand A.
- `din1` in `din1_WIDTH`: operand B.
- `acc_en` in 1: beat belongs to an accumulation sequence.
- `in_last` in 1: closes the accumulation sequence. Ignored when `acc_en`=0.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `dout` out `dout_WIDTH`: formatted result.
- `dout_ovf` out 1: result lost information (truncation, clamping or accumulator wrap).

## Operation
- Beat accepted when `in_valid && in_ready`. `din0`, `din1`, `acc_en` and `in_last` travel together through the pipe.
- Full product P has width `din0_WIDTH + din1_WIDTH`. It is computed as signed when `SIGNED`=1 and unsigned otherwise.
- Plain mode (`acc_en`=0): the result is format(P). Exactly one output per accepted beat.
- Accumulate mode (`acc_en`=1): the internal accumulator `acc` (`ACC_WIDTH`) updates to `acc + sext/zext(P)`, wrapping modulo 2^`ACC_WIDTH`.
  - Non-last beats produce no output.
  - On the last beat the output is format(acc + P). `acc` clears to 0 in that same cycle.
- Sticky `wrap` flag: set if any accumulation add in the current sequence overflows `ACC_WIDTH` in the selected signedness. It clears together with `acc`.
- Plain beats interleaved inside an open sequence pass through unaffected and leave `acc` and `wrap` untouched.
- Formatting:
  - `SAT`=0: `dout` = low `dout_WIDTH` bits. `dout_ovf`=1 iff the full value does not equal the sign/zero-extension of those bits.
  - `SAT`=1: clamp to [-2^(W-1), 2^(W-1)-1] when signed, or [0, 2^W-1] when unsigned. `dout_ovf`=1 iff a clamp occurred.
  - In both modes, `dout_ovf` is also ORed with `wrap` on an accumulate output.
- The internal stage split is free. Observable latency must be exactly `NUM_STAGE`.

## Timing
- Reset values: `out_valid`=0, `dout`=0, `dout_ovf`=0, `in_ready`=1. All stage valid bits, `acc` and `wrap` are 0.
- Global stall: pipeline advance enable is `en = !out_valid || out_ready`, and `in_ready = en`. No combinational path from `in_valid` to `in_ready`.
- Latency: a beat accepted in cycle t appears with `out_valid`=1 in cycle t+`NUM_STAGE` if `en` held throughout.
- Throughput is one beat per cycle with `out_ready`=1.
- While `out_valid && !out_ready`:
  - `dout` and `dout_ovf` hold stable.
  - No stage advances and `acc` does not update.
- Accumulate non-last beats and unaccepted cycles advance as bubbles. `out_valid` deasserts when a bubble reaches the output and the held result has been taken.
- `ap_rst_n` low at any time, including mid-sequence or mid-stall: all in-flight beats and any partial sum are discarded immediately. No output is produced for them after release.
- The first beat is accepted on the first rising edge with `ap_rst_n` high.

## Test plan
- Defaults, plain mode: `din0`=-3, `din1`=7, `out_ready`=1. Required: `dout`=10'h3EB (-21), `dout_ovf`=0, `out_valid` exactly 3 cycles after accept.
- Truncation, `SAT`=0: 300 × 3 = 900. Required: `dout`=10'h384 (-124 signed), `dout_ovf`=1. Rerun with `SAT`=1: `dout`=511 and `dout_ovf`=1. Also -300 × 3 with `SAT`=1: `dout`=-512.
- Accumulate: beats (2,3), (4,5), (-1,6 with `in_last`). Required: a single output `dout`=20, `dout_ovf`=0. An immediately following sequence (1,1 last) gives `dout`=1, proving `acc` cleared.
- Backpressure: stream plain pairs (k,1) for k=1..8 back-to-back while `out_ready` is held low for cycles 4-8. Required: outputs 1..8 in order, no loss or duplication, `in_ready` low exactly while the output is stalled, `dout` stable during the stall.
- Accumulator wrap: `ACC_WIDTH`=20, sequence of four beats (511,511) with `in_last` on the fourth. Required: `dout_ovf`=1.
- Reset mid-sequence: two accumulate beats (5,5), then pulse `ap_rst_n` low for 1 cycle, then (1,2 last). Required: `dout`=2 and no other output.
